// File: rtl/game_pkg.sv
// Shared constants for the Frogger session sequencer.
// State codes are fixed so the debug display can decode them.
package game_pkg;

  localparam int LEVEL_W = 4;
  localparam int LIVES_W = 2;
  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_PLAY      = 3'd1;
  localparam logic [STATE_W-1:0] ST_DEATH     = 3'd2;
  localparam logic [STATE_W-1:0] ST_WIN       = 3'd3;
  localparam logic [STATE_W-1:0] ST_GAME_OVER = 3'd4;
  localparam logic [STATE_W-1:0] ST_VICTORY   = 3'd5;

  typedef logic [LEVEL_W-1:0] level_t;
  typedef logic [LIVES_W-1:0] lives_t;

endpackage

// File: rtl/game_flow_ctrl_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector.
// A held input yields exactly one single-cycle pulse.
module sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic pulse
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/game_flow_ctrl.sv
// Frogger session sequencer: levels, lives, round resets and
// the freeze window around deaths and wins.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int MAX_LEVEL     = 8,
  parameter int START_LIVES   = 3,
  parameter int FREEZE_CYCLES = 12_500_000,
  parameter int GUARD_CYCLES  = 2,
  parameter int CNT_W         = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               death_collision,
  input  logic               win_collision,
  output logic [LEVEL_W-1:0] current_level,
  output logic [LIVES_W-1:0] lives,
  output logic               round_reset,
  output logic               freeze,
  output logic [STATE_W-1:0] state,
  output logic               game_over,
  output logic               victory
);

  localparam level_t          LVL_MAX  = LEVEL_W'(MAX_LEVEL);
  localparam level_t          LVL_ONE  = LEVEL_W'(1);
  localparam lives_t          LIV_INIT = LIVES_W'(START_LIVES);
  localparam logic [CNT_W-1:0] FRZ_LD  = CNT_W'(FREEZE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GRD_LD  = CNT_W'(GUARD_CYCLES);

  logic start_pulse;

  logic [STATE_W-1:0] nstate;
  level_t             nlevel;
  lives_t             nlives;
  logic [CNT_W-1:0]   fcnt;
  logic [CNT_W-1:0]   nfcnt;
  logic [CNT_W-1:0]   guard;
  logic [CNT_W-1:0]   nguard;
  logic               enter_play;

  sync_edge u_start_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (start),
    .pulse   (start_pulse)
  );

  always_comb begin
    nstate = state;
    nlevel = current_level;
    nlives = lives;
    nfcnt  = fcnt;
    nguard = guard;
    unique case (1'b1)
      (state == ST_IDLE),
      (state == ST_GAME_OVER),
      (state == ST_VICTORY): begin
        if (start_pulse) begin
          nstate = ST_PLAY;
          nlevel = LVL_ONE;
          nlives = LIV_INIT;
        end
      end
      (state == ST_PLAY): begin
        // collisions only count once the guard window has drained
        if (guard != '0) begin
          nguard = guard - 1'b1;
        end else if (death_collision) begin
          nstate = ST_DEATH;
          nfcnt  = FRZ_LD;
          if (lives != '0)
            nlives = lives - 1'b1;
        end else if (win_collision) begin
          nstate = ST_WIN;
          nfcnt  = FRZ_LD;
        end
      end
      (state == ST_DEATH): begin
        if (fcnt != '0)
          nfcnt = fcnt - 1'b1;
        else if (lives == '0)
          nstate = ST_GAME_OVER;
        else
          nstate = ST_PLAY;
      end
      (state == ST_WIN): begin
        if (fcnt != '0) begin
          nfcnt = fcnt - 1'b1;
        end else if (current_level >= LVL_MAX) begin
          nstate = ST_VICTORY;
        end else begin
          nstate = ST_PLAY;
          nlevel = current_level + 1'b1;
        end
      end
      default: nstate = ST_IDLE;
    endcase
    enter_play = (nstate == ST_PLAY) && (state != ST_PLAY);
    if (enter_play)
      nguard = GRD_LD;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      current_level <= LVL_ONE;
      lives         <= LIV_INIT;
      round_reset   <= 1'b0;
      freeze        <= 1'b1;
      game_over     <= 1'b0;
      victory       <= 1'b0;
      fcnt          <= '0;
      guard         <= '0;
    end else begin
      state         <= nstate;
      current_level <= nlevel;
      lives         <= nlives;
      round_reset   <= enter_play;
      freeze        <= (nstate != ST_PLAY);
      game_over     <= (nstate == ST_GAME_OVER);
      victory       <= (nstate == ST_VICTORY);
      fcnt          <= nfcnt;
      guard         <= nguard;
    end
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Sequences one Frogger game session. Sits directly downstream of the collision checker and upstream of the frog, car and VGA blocks. Consumes death/win collision levels and a start request. Produces the current level, remaining lives, a one-cycle round-reset pulse to the frog and cars, and a freeze level that halts motion during death/win pauses.

Parameters:
MAX_LEVEL, 8, last playable level; clearing it enters VICTORY
START_LIVES, 3, lives loaded at game start (1..3)
FREEZE_CYCLES, 12_500_000, pause length in clk cycles after death or win (0.5 s at 25 MHz); must be >= 2
GUARD_CYCLES, 2, cycles after round start during which collisions are ignored
CNT_W, 24, freeze counter width; must satisfy 2^CNT_W > FREEZE_CYCLES

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  asynchronous start request (OR of switches), level
death_collision  in  1  frog overlaps a car, level, combinational from collision checker
win_collision  in  1  frog reached goal row, level
current_level  out  4  level 1..MAX_LEVEL, drives car speeds and 7-seg
lives  out  2  remaining lives
round_reset  out  1  one-cycle pulse; frog and cars return to start positions
freeze  out  1  high = frog and cars hold position
state  out  3  FSM state encoding, for display/debug
game_over  out  1  high in GAME_OVER
victory  out  1  high in VICTORY

Behaviour:
- All flops reset asynchronously on reset_n low. Reset values: state=IDLE, current_level=1, lives=START_LIVES, round_reset=0, freeze=1, game_over=0, victory=0, counters=0.
- start passes through a 2-flop synchronizer and rising-edge detect. start_pulse is high for one cycle, 2 edges after start is first sampled high. A held start produces exactly one pulse.
- All outputs are registered. freeze = (state != PLAY).
- States:
  - IDLE: on start_pulse, go to PLAY; load level=1, lives=START_LIVES; round_reset=1.
  - PLAY: guard counter loads GUARD_CYCLES on entry. Collisions are ignored while guard != 0.
    - After the guard, death_collision → DEATH with lives-1 and freeze counter = FREEZE_CYCLES-1.
    - Otherwise win_collision → WIN with freeze counter = FREEZE_CYCLES-1.
    - If both are asserted on the same cycle, death has priority and win is discarded.
  - DEATH: count down to 0. At 0: lives==0 → GAME_OVER; else → PLAY with round_reset=1. Level is unchanged.
  - WIN: count down to 0. At 0: level==MAX_LEVEL → VICTORY, level held; else level+1 → PLAY with round_reset=1.
  - GAME_OVER / VICTORY: hold level and lives. On start_pulse → PLAY with level=1, lives=START_LIVES, round_reset=1.
- round_reset is high exactly on the first cycle in which state==PLAY, and never otherwise.
- Collisions are ignored in every state except PLAY (post-guard).
- The start request is ignored in PLAY, DEATH and WIN.
- lives never underflows: decrement happens only on the PLAY→DEATH transition, and lives==0 exits to GAME_OVER.
- current_level is saturated at MAX_LEVEL and never wraps to 0.
- reset_n asserted mid-pause aborts the count immediately and returns all outputs to reset values.
- Timing: death_collision sampled at edge k (post-guard) → state=DEATH, freeze=1 after edge k. PLAY resumes FREEZE_CYCLES edges later.

Decomposition:
- Package game_pkg holds:
  - state encoding: IDLE=0, PLAY=1, DEATH=2, WIN=3, GAME_OVER=4, VICTORY=5
  - the LEVEL_W=4 and LIVES_W=2 constants
- One sub-module, sync_edge, contains the 2-flop synchronizer plus rising-edge detector. It has the same clk/reset_n ports and is reused for the movement switches.
- FSM, freeze counter and guard counter live in game_flow_ctrl.

Test Plan:
Run with FREEZE_CYCLES=4, GUARD_CYCLES=2, START_LIVES=3, MAX_LEVEL=3.
- Reset then start high for 10 cycles → exactly one round_reset pulse; state=PLAY; level=1; lives=3; freeze=0.
- In PLAY after guard, death_collision held high → DEATH next edge; lives=2; freeze high 4 cycles; one round_reset; PLAY with level=1.
- Three deaths in a row → after the third pause, state=GAME_OVER, game_over=1, lives=0, no round_reset. A new start restores level=1, lives=3.
- Win on levels 1, 2, 3 → level 2, 3, then VICTORY with level held at 3 and victory=1.
- death_collision and win_collision high on the same cycle → DEATH, lives decremented, level unchanged. Collision asserted during the first 2 PLAY cycles → ignored.
- reset_n pulsed low during the WIN pause → outputs immediately at reset values. start during DEATH → no effect.
